ltc2311_sample_averager: RTL and testbench
==========================================

Name: ltc2311_sample_averager

Overview:
Downstream consumer of the LTC2311-16 reader's sample stream (16-bit sample with a single-cycle valid pulse).
- Averages blocks of 2^LOG2_AVG consecutive two's-complement samples into one decimated result.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the system side (DMA or register bank).
- Flags results lost to back-pressure with a sticky overrun bit.

Parameters:
LOG2_AVG, 2, log2 of samples per average; legal range 0..8; 0 = pass-through.
FIFO_DEPTH, 4, result FIFO depth; power of two, >= 2.

Ports:
clk  in  1  system clock; also clocks the reader.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  when low, incoming samples are ignored; accumulator and count are held.
clear  in  1  synchronous flush: accumulator, count, FIFO and overrun all cleared.
in_data  in  16  sample from the reader, two's complement.
in_valid  in  1  sample strobe; each high cycle is one sample.
out_data  out  16  averaged result, two's complement.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of results stored.
overrun  out  1  sticky; set when a result is dropped because the FIFO is full.

Behaviour:
- Reset values: out_data=0, out_valid=0, fifo_level=0, overrun=0. Accumulator=0, sample count=0, FIFO pointers=0.
- Reset mid-block discards the partial sum and all FIFO contents.
- Accumulator width: 16+LOG2_AVG bits, signed. Each sample is sign-extended before adding, so no internal overflow is possible.
- Sample accept: on an edge with in_valid && enable && !clear, acc <= acc + sext(in_data) and count <= count + 1.
- Block complete: on the edge accepting sample number 2^LOG2_AVG:
  - result = (acc + sext(in_data)) >>> LOG2_AVG, arithmetic shift (floor toward -inf).
  - result is truncated to 16 bits; it always fits.
  - result is pushed into the FIFO on that same edge.
  - acc and count return to 0 on that same edge.
- Latency: out_valid rises the cycle after the edge accepting the last sample of a block, if the FIFO was empty.
- Pop: on an edge with out_valid && out_ready, the head is removed. out_data is first-word-fall-through, i.e. combinationally equal to the FIFO head. out_data is unspecified while out_valid=0, but the bench checks only when valid.
- Push and pop on the same edge:
  - fifo_level unchanged.
  - Push succeeds even when the FIFO is full, because the pop frees the slot.
- Full, push, no pop: result dropped, FIFO unchanged, overrun <= 1. Block accounting still restarts: acc and count go to 0.
- overrun clears only on clear or reset.
- clear has priority over in_valid and out_ready on the same edge:
  - the sample is discarded;
  - no pop is performed;
  - the next cycle shows out_valid=0, fifo_level=0, overrun=0.
- enable low: in_valid is ignored, the partial block is retained, and the FIFO still drains normally.
- LOG2_AVG=0: every accepted sample is pushed unchanged on its accept edge.
- Back-to-back in_valid on every cycle is supported; the reader's rate is much lower, but the block must not depend on that.
- Counter width: LOG2_AVG+1 bits. The compare value is 2^LOG2_AVG-1 with the current sample valid, so there is no wrap ambiguity at LOG2_AVG=8.
- Only one state variable beyond the FIFO: the count. No FSM is needed beyond counter/FIFO control.

Decomposition:
- Package ltc2311_pkg:
  - SAMPLE_W=16;
  - typedef logic signed [SAMPLE_W-1:0] sample_t;
  - later shared by the reader and its neighbours.
- Sub-module ltc2311_sample_fifo: generic synchronous first-word-fall-through FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, empty, full, level.
  - Same clk/reset_n.
- The averager instantiates it and holds the accumulate/decimate logic.

Test Plan:
1. LOG2_AVG=2, out_ready=1, samples 100,200,300,400 -> one result 250 (0x00FA); out_valid high exactly 1 cycle, starting the cycle after the 4th sample edge.
2. Samples -1,-2,-3,-4 -> sum -10 >>>2 = -3 (0xFFFD). Then 4x 0x7FFF -> 0x7FFF, and 4x 0x8000 -> 0x8000.
3. out_ready=0, 20 samples of value 5 -> fifo_level=4, 5th result dropped, overrun=1. Then out_ready=1 -> four pops of 5, out_valid falls, overrun stays 1 until clear.
4. FIFO full, last sample of a block arrives on the same edge as a pop -> push succeeds; fifo_level stays 4; overrun stays 0.
5. Two samples 1000, then clear, then 4 samples of 8 -> single result 8 (partial sum discarded). Separately, enable=0 during 2 pulses mid-block -> those pulses are ignored and the block completes after 4 enabled samples.
6. reset_n asserted mid-block with 2 results queued -> out_valid=0, fifo_level=0, overrun=0 asynchronously. The next 4 samples 10,10,10,10 -> result 10.

Source files
------------

// File: rtl/ltc2311_pkg.sv
// Shared types for the LTC2311-16 reader and its downstream blocks.
package ltc2311_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/ltc2311_sample_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module ltc2311_sample_fifo
    import ltc2311_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_en, pop_en;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Pointer and occupancy update; clr flushes without touching storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_en && !pop_en)      level_d = level_q + LW'(1);
            else if (!push_en && pop_en) level_d = level_q - LW'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en && !clr) mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ltc2311_sample_averager.sv
// Averages blocks of 2^LOG2_AVG signed samples and queues the decimated
// results for a valid/ready consumer, flagging results lost to back-pressure.
module ltc2311_sample_averager
    import ltc2311_pkg::*;
#(
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [SAMPLE_W-1:0]           in_data,
    input  logic                          in_valid,
    output logic [SAMPLE_W-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun
);

    localparam int ACC_W = SAMPLE_W + LOG2_AVG;
    localparam int CW    = LOG2_AVG + 1;
    localparam int unsigned CNT_LAST_I = (1 << LOG2_AVG) - 1;
    localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum, quot;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    overrun_q, overrun_d;
    sample_t                 sample_s, result;
    logic                    accept, last, pop, fifo_empty, fifo_full;

    assign sample_s  = sample_t'(in_data);
    assign sum       = acc_q + ACC_W'(sample_s);
    assign quot      = sum >>> LOG2_AVG;
    assign result    = sample_t'(quot);
    assign accept    = in_valid && enable && !clear;
    assign last      = accept && (cnt_q == CNT_LAST);
    assign pop       = out_valid && out_ready && !clear;
    assign out_valid = !fifo_empty;
    assign overrun   = overrun_q;

    // Accumulate, restart the block on its last sample, track dropped results.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
                if (fifo_full && !pop) overrun_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Accumulator, sample count and sticky overrun registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    ltc2311_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .push    (last),
        .pop     (pop),
        .wdata   (result),
        .rdata   (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_ltc2311_sample_averager.sv
// Directed bench for the sample averager (LOG2_AVG=2, FIFO_DEPTH=4).
module tb_ltc2311_sample_averager;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    ltc2311_sample_averager #(
        .LOG2_AVG   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One sample over one edge; consecutive calls are back-to-back.
    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [15:0] drain_exp [4];

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_level",   32'(fifo_level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data",    32'(out_data), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: basic average, one-cycle valid with out_ready high
        send(16'd100); send(16'd200); send(16'd300);
        chk("t1_no_early_valid", 32'(out_valid), 32'd0);
        send(16'd400);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data), 32'h00FA);
        tick();
        chk("t1_valid_fall", 32'(out_valid), 32'd0);
        chk("t1_level0",     32'(fifo_level), 32'd0);

        // 2: negative and extreme values
        send(16'hFFFF); send(16'hFFFE); send(16'hFFFD); send(16'hFFFC);
        chk("t2_neg", 32'(out_data), 32'hFFFD);
        for (int i = 0; i < 4; i++) send(16'h7FFF);
        chk("t2_max", 32'(out_data), 32'h7FFF);
        for (int i = 0; i < 4; i++) send(16'h8000);
        chk("t2_min", 32'(out_data), 32'h8000);
        tick();

        // 3: back-pressure, overrun, drain
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'd5);
        chk("t3_full_level",   32'(fifo_level), 32'd4);
        chk("t3_no_overrun",   32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) send(16'd5);
        chk("t3_level_held",   32'(fifo_level), 32'd4);
        chk("t3_overrun",      32'(overrun), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", 32'(out_valid), 32'd1);
            chk("t3_drain_data",  32'(out_data), 32'd5);
            tick();
        end
        chk("t3_empty",          32'(out_valid), 32'd0);
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);
        pulse_clear();
        chk("t3_overrun_clr",    32'(overrun), 32'd0);

        // 4: push into full FIFO on a pop edge
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'd5);
        send(16'd9); send(16'd9); send(16'd9);
        out_ready = 1'b1;
        send(16'd9);
        out_ready = 1'b0;
        chk("t4_level",   32'(fifo_level), 32'd4);
        chk("t4_overrun", 32'(overrun), 32'd0);
        drain_exp = '{16'd5, 16'd5, 16'd5, 16'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", 32'(out_data), 32'(drain_exp[i]));
            tick();
        end
        chk("t4_level0", 32'(fifo_level), 32'd0);

        // 5: clear discards partial sum; enable gating
        send(16'd1000); send(16'd1000);
        pulse_clear();
        send(16'd8); send(16'd8); send(16'd8);
        chk("t5_not_yet", 32'(out_valid), 32'd0);
        send(16'd8);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_data",  32'(out_data), 32'd8);
        tick();
        send(16'd20); send(16'd20);
        enable = 1'b0;
        send(16'd1000); send(16'd1000);
        chk("t5_en_ignored", 32'(out_valid), 32'd0);
        enable = 1'b1;
        send(16'd20);
        chk("t5_en_partial", 32'(out_valid), 32'd0);
        send(16'd20);
        chk("t5_en_valid", 32'(out_valid), 32'd1);
        chk("t5_en_data",  32'(out_data), 32'd20);
        tick();

        // 6: asynchronous reset mid-block with results queued
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(16'd3);
        chk("t6_queued", 32'(fifo_level), 32'd2);
        reset_n = 1'b0;
        #2;
        chk("t6_rst_valid",   32'(out_valid), 32'd0);
        chk("t6_rst_level",   32'(fifo_level), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(16'd10); send(16'd10); send(16'd10);
        chk("t6_partial_gone", 32'(out_valid), 32'd0);
        send(16'd10);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data",  32'(out_data), 32'd10);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
